// File: rtl/hdmi_pkg.sv
// Shared HDMI/DVI transmit constants and the TMDS control-token lookup.
package hdmi_pkg;

   localparam int TMDS_WIDTH  = 10;
   localparam int PIXEL_WIDTH = 8;

   localparam logic [TMDS_WIDTH-1:0] TMDS_CTRL_00 = 10'b1101010100;
   localparam logic [TMDS_WIDTH-1:0] TMDS_CTRL_01 = 10'b0010101011;
   localparam logic [TMDS_WIDTH-1:0] TMDS_CTRL_10 = 10'b0101010100;
   localparam logic [TMDS_WIDTH-1:0] TMDS_CTRL_11 = 10'b1010101011;

   // Control token for {c1,c0} during blanking.
   function automatic logic [TMDS_WIDTH-1:0] tmds_ctrl_token(input logic [1:0] ctrl);
      logic [TMDS_WIDTH-1:0] tok;
      case (ctrl)
         2'b00:   tok = TMDS_CTRL_00;
         2'b01:   tok = TMDS_CTRL_01;
         2'b10:   tok = TMDS_CTRL_10;
         default: tok = TMDS_CTRL_11;
      endcase
      return tok;
   endfunction

endpackage

// File: rtl/tmds_popcount8.sv
// Combinational ones count of an 8-bit word.
module tmds_popcount8 (
   input  logic [7:0] bits,
   output logic [3:0] ones
);

   // Sum the set bits.
   always_comb begin
      ones = '0;
      for (int i = 0; i < 8; i++) begin
         ones = ones + 4'(bits[i]);
      end
   end

endmodule

// File: rtl/tmds_encoder.sv
// TMDS 8b/10b encoder for one channel. Stage 1 forms the transition-minimised
// word q_m, a holding stage aligns it for a two-cycle latency, and the final
// stage applies DC balancing against the running disparity or emits a control token.
module tmds_encoder
   import hdmi_pkg::*;
#(
   parameter int DATA_WIDTH = PIXEL_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  de,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  c0,
   input  logic                  c1,
   output logic [TMDS_WIDTH-1:0] tmds_out
);

   logic [3:0]            ones_d;
   logic                  use_xnor;
   logic [8:0]            q_m_c;

   logic                  de_s1;
   logic [1:0]            ctrl_s1;
   logic [8:0]            q_m_s1;

   logic                  de_s2;
   logic [1:0]            ctrl_s2;
   logic [8:0]            q_m_s2;

   logic [3:0]            n1;
   logic signed [4:0]     n1_s;
   logic signed [4:0]     n0_s;
   logic signed [4:0]     diff;
   logic signed [4:0]     cnt;
   logic signed [4:0]     cnt_nxt;
   logic [TMDS_WIDTH-1:0] out_nxt;

   tmds_popcount8 u_pop_data (
      .bits (data_in),
      .ones (ones_d)
   );

   // Choose XOR or XNOR chaining so the data word has the fewest transitions.
   always_comb begin
      use_xnor = (ones_d > 4'd4) || ((ones_d == 4'd4) && !data_in[0]);
      q_m_c    = '0;
      q_m_c[0] = data_in[0];
      for (int i = 1; i < 8; i++) begin
         q_m_c[i] = use_xnor ? ~(q_m_c[i-1] ^ data_in[i]) : (q_m_c[i-1] ^ data_in[i]);
      end
      q_m_c[8] = ~use_xnor;
   end

   // Stage 1 register: transition-minimised word plus control/enable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         de_s1   <= 1'b0;
         ctrl_s1 <= 2'b00;
         q_m_s1  <= '0;
      end else begin
         de_s1   <= de;
         ctrl_s1 <= {c1, c0};
         q_m_s1  <= q_m_c;
      end
   end

   // Holding register so a character sampled at edge k leaves after edge k+2.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         de_s2   <= 1'b0;
         ctrl_s2 <= 2'b00;
         q_m_s2  <= '0;
      end else begin
         de_s2   <= de_s1;
         ctrl_s2 <= ctrl_s1;
         q_m_s2  <= q_m_s1;
      end
   end

   tmds_popcount8 u_pop_qm (
      .bits (q_m_s2[7:0]),
      .ones (n1)
   );

   // DC balancing: pick inversion from the running disparity and update it.
   always_comb begin
      n1_s    = signed'({1'b0, n1});
      n0_s    = 5'sd8 - n1_s;
      diff    = n1_s - n0_s;
      cnt_nxt = cnt;
      out_nxt = TMDS_CTRL_00;
      if (!de_s2) begin
         cnt_nxt = 5'sd0;
         out_nxt = tmds_ctrl_token(ctrl_s2);
      end else if ((cnt == 5'sd0) || (n1 == 4'd4)) begin
         out_nxt = {~q_m_s2[8], q_m_s2[8], q_m_s2[8] ? q_m_s2[7:0] : ~q_m_s2[7:0]};
         cnt_nxt = q_m_s2[8] ? (cnt + diff) : (cnt - diff);
      end else if (((cnt > 5'sd0) && (n1 > 4'd4)) || ((cnt < 5'sd0) && (n1 < 4'd4))) begin
         out_nxt = {1'b1, q_m_s2[8], ~q_m_s2[7:0]};
         cnt_nxt = cnt + (q_m_s2[8] ? 5'sd2 : 5'sd0) - diff;
      end else begin
         out_nxt = {1'b0, q_m_s2[8], q_m_s2[7:0]};
         cnt_nxt = cnt + diff - (q_m_s2[8] ? 5'sd0 : 5'sd2);
      end
   end

   // Output character and running disparity register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmds_out <= TMDS_CTRL_00;
         cnt      <= 5'sd0;
      end else begin
         tmds_out <= out_nxt;
         cnt      <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_tmds_encoder.sv
// Self-checking bench for tmds_encoder: behavioural model plus directed literals.
module tb_tmds_encoder;
   import hdmi_pkg::*;

   logic       clk     = 1'b0;
   logic       rst_n   = 1'b1;
   logic       de      = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       c0      = 1'b0;
   logic       c1      = 1'b0;
   logic [9:0] tmds_out;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   tmds_encoder #(.DATA_WIDTH(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .de       (de),
      .data_in  (data_in),
      .c0       (c0),
      .c1       (c1),
      .tmds_out (tmds_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
      end
   endtask

   // Reference encoder working on integers; updates the running disparity.
   function automatic logic [9:0] model_encode(input logic de_i, input logic [7:0] d,
                                               input logic [1:0] ctrl, inout int disp);
      int         nd, n1, n0, q8;
      logic       inv;
      logic [8:0] qm;
      if (!de_i) begin
         disp = 0;
         case (ctrl)
            2'd0:    return 10'h354;
            2'd1:    return 10'h0AB;
            2'd2:    return 10'h154;
            default: return 10'h2AB;
         endcase
      end
      nd    = $countones(d);
      inv   = (nd > 4) || (nd == 4 && d[0] == 1'b0);
      qm    = '0;
      qm[0] = d[0];
      for (int i = 1; i < 8; i++) qm[i] = inv ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
      qm[8] = ~inv;
      q8    = int'(qm[8]);
      n1    = $countones(qm[7:0]);
      n0    = 8 - n1;
      if (disp == 0 || n1 == n0) begin
         if (q8 == 1) begin
            disp += n1 - n0;
            return {2'b01, qm[7:0]};
         end
         disp += n0 - n1;
         return {2'b10, ~qm[7:0]};
      end
      if ((disp > 0 && n1 > n0) || (disp < 0 && n0 > n1)) begin
         disp += 2 * q8 + (n0 - n1);
         return {1'b1, qm[8], ~qm[7:0]};
      end
      disp += (n1 - n0) - 2 * (1 - q8);
      return {1'b0, qm[8], qm[7:0]};
   endfunction

   int         m_disp = 0;
   logic [9:0] opipe[2] = '{10'h354, 10'h354};
   int         cpipe[2] = '{0, 0};
   logic [9:0] exp_out = 10'h354;
   int         exp_cnt = 0;
   logic [9:0] m_o;

   // Two-deep expectation pipe fed at each sampling edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_disp  = 0;
         opipe   = '{10'h354, 10'h354};
         cpipe   = '{0, 0};
         exp_out = 10'h354;
         exp_cnt = 0;
      end else begin
         exp_out  = opipe[1];
         exp_cnt  = cpipe[1];
         opipe[1] = opipe[0];
         cpipe[1] = cpipe[0];
         m_o      = model_encode(de, data_in, {c1, c0}, m_disp);
         opipe[0] = m_o;
         cpipe[0] = m_disp;
      end
   end

   // Compare DUT against the model every cycle.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("model tmds_out", int'(tmds_out), int'(exp_out));
         check("model cnt", int'($signed(dut.cnt)), exp_cnt);
         checks++;
         if ($signed(dut.cnt) < -8 || $signed(dut.cnt) > 8) begin
            errors++;
            $display("FAIL cnt range: got %0d required -8..8", $signed(dut.cnt));
         end
      end
   end

   logic       dde[32];
   logic [7:0] dd[32];
   logic [1:0] dc[32];
   logic [9:0] dexp[32];
   int         dcnt[32];
   int         dlen = 0;

   task automatic add(input logic de_i, input logic [7:0] d, input logic [1:0] c,
                      input logic [9:0] e, input int k);
      dde[dlen]  = de_i;
      dd[dlen]   = d;
      dc[dlen]   = c;
      dexp[dlen] = e;
      dcnt[dlen] = k;
      dlen++;
   endtask

   task automatic run_dir(input string name);
      for (int j = 0; j < dlen + 3; j++) begin
         @(negedge clk);
         if (j >= 3) begin
            check({name, " out"}, int'(tmds_out), int'(dexp[j-3]));
            check({name, " cnt"}, int'($signed(dut.cnt)), dcnt[j-3]);
         end
         if (j < dlen) begin
            de = dde[j]; data_in = dd[j]; {c1, c0} = dc[j];
         end else begin
            de = 1'b0; data_in = 8'h00; {c1, c0} = 2'b00;
         end
      end
      dlen = 0;
   endtask

   int walk_cnt[9] = '{-8, 2, -6, 4, -4, 6, -2, 8, 0};

   initial begin
      // Reset and idle
      #1 rst_n = 1'b0;
      cmp_en = 1'b1;
      #1 check("reset out", int'(tmds_out), 'h354);
      repeat (3) begin
         @(negedge clk);
         check("reset hold", int'(tmds_out), 'h354);
      end
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("idle out", int'(tmds_out), 'h354);
      end

      // Control tokens
      add(0, 8'h00, 2'b00, 10'h354, 0);
      add(0, 8'h00, 2'b01, 10'h0AB, 0);
      add(0, 8'h00, 2'b10, 10'h154, 0);
      add(0, 8'h00, 2'b11, 10'h2AB, 0);
      run_dir("ctrl");

      // Disparity walk with 0x00
      add(0, 8'h00, 2'b00, 10'h354, 0);
      for (int i = 0; i < 9; i++) add(1, 8'h00, 2'b00, (i % 2 == 0) ? 10'h100 : 10'h3FF, walk_cnt[i]);
      run_dir("walk");

      // XNOR path
      add(0, 8'h00, 2'b00, 10'h354, 0);
      add(1, 8'hFF, 2'b00, 10'h200, -8);
      run_dir("xnor");

      // Blank clears disparity
      add(0, 8'h00, 2'b00, 10'h354, 0);
      add(1, 8'h00, 2'b00, 10'h100, -8);
      add(1, 8'h00, 2'b00, 10'h3FF, 2);
      add(0, 8'h00, 2'b00, 10'h354, 0);
      add(1, 8'h00, 2'b00, 10'h100, -8);
      run_dir("blank clear");

      // Reset mid-line
      @(negedge clk);
      de = 1'b1; data_in = 8'h00;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check("midline reset out", int'(tmds_out), 'h354);
      check("midline reset cnt", int'($signed(dut.cnt)), 0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      check("post reset 1", int'(tmds_out), 'h354);
      @(negedge clk);
      check("post reset 2", int'(tmds_out), 'h354);
      @(negedge clk);
      check("post reset data", int'(tmds_out), 'h100);
      check("post reset cnt", int'($signed(dut.cnt)), -8);

      // Random traffic, including a stretch of de toggling every cycle
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (i >= 1000 && i < 1100) de = (i % 2 == 0);
         else de = ($urandom_range(0, 7) != 0);
         data_in  = 8'($urandom);
         {c1, c0} = 2'($urandom_range(0, 3));
         if (i == 2000) begin
            #2 rst_n = 1'b0;
            #3 rst_n = 1'b1;
         end
      end
      @(negedge clk);
      de = 1'b0; {c1, c0} = 2'b00;
      repeat (4) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tmds_encoder.md
# tmds_encoder

Pixel-clock-domain TMDS 8b/10b encoder for one HDMI/DVI channel. Converts an 8-bit pixel component, or a 2-bit control code during blanking, into a DC-balanced 10-bit TMDS character. Sits directly upstream of the 10-bit PISO serializer, which loads `tmds_out` and shifts it out LSB-first. Three instances, one per channel, form the TMDS transmit path.

## Interface
- `DATA_WIDTH`, 8: pixel component width. Fixed by the algorithm; only 8 is legal.
- `clk`  in  1: pixel clock.
- `rst_n`  in  1: reset. Asynchronous assert, active-low.
- `de`  in  1: data enable. 1 means active video and `data_in` is encoded; 0 means blanking and `{c1,c0}` is encoded.
- `data_in`  in  8: pixel component. Sampled only when `de`=1.
- `c0`  in  1: control bit 0 (HSYNC on channel 0).
- `c1`  in  1: control bit 1 (VSYNC on channel 0).
- `tmds_out`  out  10: encoded character, registered. Bit 0 is transmitted first.

## Operation
- Pipeline stage 1 registers `de`, `c0`, `c1` and `q_m[8:0]`, where `q_m` is computed from `data_in` with N1 = popcount(`data_in`):
  - If N1>4, or N1==4 and `data_in[0]`==0: `q_m[0]=d[0]`, `q_m[i]=~(q_m[i-1]^d[i])`, `q_m[8]=0`.
  - Otherwise: `q_m[0]=d[0]`, `q_m[i]=q_m[i-1]^d[i]`, `q_m[8]=1`.
- Stage 2 computes n1 = popcount(`q_m[7:0]`) and n0 = 8−n1, using running disparity `cnt`.
  - `cnt` is a signed 5-bit register. Its legal range is −8..+8 and it never wraps in legal operation.
- Stage 2, when registered `de`=1:
  - **Case A** (`cnt`==0 or n1==n0): output = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
    - If q_m[8]=1: `cnt` += n1−n0. Otherwise: `cnt` += n0−n1.
  - **Case B** (`cnt`>0 and n1>n0, or `cnt`<0 and n0>n1): output = {1, q_m[8], ~q_m[7:0]}.
    - `cnt` += 2·q_m[8] + (n0−n1).
  - **Case C** (all other conditions): output = {0, q_m[8], q_m[7:0]}.
    - `cnt` += (n1−n0) − 2·(~q_m[8]).
- Stage 2, when registered `de`=0:
  - `cnt` is set to 0.
  - Output is the control token for {c1,c0}: 00→10'b1101010100 (0x354), 01→10'b0010101011 (0x0AB), 10→10'b0101010100 (0x154), 11→10'b1010101011 (0x2AB).
- No backpressure and no handshake. A new character is produced every `clk`.

## Timing
- Latency is 2 cycles. Inputs sampled at rising edge k appear on `tmds_out` after edge k+2.
- Throughput is 1 character per cycle.
- `rst_n` low, at any time including mid-line:
  - `tmds_out` = 0x354 immediately (asynchronous).
  - `cnt` = 0. Both pipeline `de` bits = 0. Stage-1 `c0`/`c1` = 0.
  - Every output after release is 0x354 until the first sampled input reaches stage 2.
- `de` falling edge: the first blanking character leaves stage 2 two edges after `de` is sampled low, and `cnt` clears on that same edge.
- `de` rising edge: the first data character is encoded with `cnt`=0.
- `de` toggling every cycle is legal. Each character is handled independently according to its own pipelined `de`.
- `data_in` is ignored when `de`=0. `c0`/`c1` are ignored when `de`=1.

## Structure
- Shared package `hdmi_pkg`:
  - Constants `TMDS_CTRL_00`, `TMDS_CTRL_01`, `TMDS_CTRL_10`, `TMDS_CTRL_11`.
  - `TMDS_WIDTH`=10.
  - `PIXEL_WIDTH`=8.
- Sub-module `tmds_popcount8`: combinational 8-bit ones count, 4-bit result. Instantiated twice, once in stage 1 and once in stage 2.
- All disparity arithmetic is done in signed 5-bit. Popcounts are zero-extended before subtraction.

## Test plan
- Reset and idle: hold `rst_n`=0, then release with `de`=0 and {c1,c0}=00.
  - Expect `tmds_out`=0x354 throughout reset and on every cycle after release.
- Control tokens: with `de`=0, apply {c1,c0}=00, 01, 10, 11 on consecutive cycles.
  - Expect 0x354, 0x0AB, 0x154, 0x2AB, starting 2 cycles later.
- Disparity walk: after blanking, drive `de`=1 with `data_in`=0x00 continuously.
  - Expect `tmds_out` = 0x100, 0x3FF, 0x100, 0x3FF, …
  - Expect internal `cnt` = −8, +2, −6, +4, −4, +6, −2, +8, 0.
- XNOR path: after blanking, drive `de`=1 with `data_in`=0xFF for one cycle.
  - Expect `tmds_out`=0x200 and `cnt`=−8.
- Blank clears disparity: drive two data characters of 0x00 (`cnt` reaches +2), then 1 cycle `de`=0, then 0x00.
  - Expect the post-blank output = 0x100, confirming `cnt` restarted at 0.
- Reset mid-line: assert `rst_n` during active video with `cnt`≠0.
  - Expect `tmds_out`=0x354 asynchronously.
  - After release, the first 0x00 data character encodes as 0x100.
- Random check: drive random `de`, `data_in`, `c0`, `c1` against a reference model.
  - Expect bit-exact match, and `cnt` always within −8..+8.
